// File: rtl/wide_buffer_pkg.sv
// Shared types for the wide data buffer: transfer size encoding and lane count.
// Latency n/a; no backpressure (types and helpers only).
package wide_buffer_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam int WORD_BYTES = 4;

    // Size code 3 is illegal and maps to zero bytes so callers can flag it.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/buffer_ram.sv
// DEPTH x 8 byte store with one 1-4 byte write lane group and one 1-4 byte combinational read.
// Write lands on the clock edge, read is combinational; no backpressure, contents never reset.
module buffer_ram
    import wide_buffer_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    i_wr_en,
    input  logic [AW-1:0]           i_wr_ptr,
    input  logic [2:0]              i_wr_bytes,
    input  logic [8*WORD_BYTES-1:0] i_wr_dat,
    input  logic [AW-1:0]           i_rd_ptr,
    input  logic [2:0]              i_rd_bytes,
    output logic [8*WORD_BYTES-1:0] o_rd_dat
);

    logic [7:0]    r_mem  [DEPTH];
    logic [AW-1:0] w_wa   [WORD_BYTES];
    logic [AW-1:0] w_ra   [WORD_BYTES];

    // Lane addresses wrap naturally because DEPTH is a power of two.
    always_comb begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            w_wa[i] = i_wr_ptr + AW'(i);
            w_ra[i] = i_rd_ptr + AW'(i);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i_wr_en && (3'(i) < i_wr_bytes)) begin
                r_mem[w_wa[i]] <= i_wr_dat[8*i +: 8];
            end
        end
    end

    // Lanes beyond the requested size read as zero.
    always_comb begin
        o_rd_dat = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (3'(i) < i_rd_bytes) begin
                o_rd_dat[8*i +: 8] = r_mem[w_ra[i]];
            end
        end
    end

endmodule

// File: rtl/wide_data_buffer.sv
// Circular byte buffer between USB (byte) and AHB (1/2/4 byte) sides; pop data registered, 1-cycle latency.
// No backpressure: illegal, conflicting or over/underflowing requests are dropped and set sticky buf_err. Option: WIDE_DATA_BUFFER_WATERMARK_EN adds level_hit.
module wide_data_buffer
    import wide_buffer_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int OCC_W = $clog2(DEPTH) + 1
`ifdef WIDE_DATA_BUFFER_WATERMARK_EN
    ,
    parameter int WATERMARK = DEPTH / 2
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             flush,
    input  logic             store_rx_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             get_tx_data,
    output logic [7:0]       tx_packet_data,
    input  logic             store_tx_data,
    input  logic [31:0]      tx_data,
    input  logic [1:0]       tx_size,
    input  logic             get_rx_data,
    input  logic [1:0]       rx_size,
    output logic [31:0]      rx_data,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic             empty,
    output logic             full,
    output logic             buf_err
`ifdef WIDE_DATA_BUFFER_WATERMARK_EN
    ,
    output logic             level_hit
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = OCC_W + 1;

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [OCC_W-1:0] r_count;
    logic [7:0]       r_tx_dat;
    logic [31:0]      r_rx_dat;
    logic             r_err;

    logic [2:0]       w_pop_n;
    logic             w_pop_tx;
    logic             w_pop_ok;
    logic [2:0]       w_push_n;
    logic [31:0]      w_push_dat;
    logic             w_push_ok;
    logic             w_req_err;
    logic             w_err_set;
    logic             w_empty_req;
    logic [CW-1:0]    w_cnt_mid;
    logic [CW-1:0]    w_cnt_nxt;
    logic [31:0]      w_rd_dat;

    assign w_empty_req = clear | flush;

    always_comb begin
        w_pop_n    = 3'd0;
        w_pop_tx   = 1'b0;
        w_push_n   = 3'd0;
        w_push_dat = tx_data;
        w_req_err  = 1'b0;

        if (get_tx_data) begin
            w_pop_n  = 3'd1;
            w_pop_tx = 1'b1;
            w_req_err = w_req_err | get_rx_data;
        end else if (get_rx_data) begin
            w_pop_n   = size_to_bytes(rx_size);
            w_req_err = w_req_err | (w_pop_n == 3'd0);
        end

        if (store_rx_data) begin
            w_push_n   = 3'd1;
            w_push_dat = {24'h0, rx_packet_data};
            w_req_err  = w_req_err | store_tx_data;
        end else if (store_tx_data) begin
            w_push_n  = size_to_bytes(tx_size);
            w_req_err = w_req_err | (w_push_n == 3'd0);
        end

        // Pop is judged on the pre-edge count; push sees the space the pop frees.
        w_pop_ok  = (w_pop_n != 3'd0) && (CW'(w_pop_n) <= CW'(r_count));
        w_cnt_mid = CW'(r_count) - (w_pop_ok ? CW'(w_pop_n) : '0);
        w_push_ok = (w_push_n != 3'd0) && ((w_cnt_mid + CW'(w_push_n)) <= CW'(DEPTH));
        w_cnt_nxt = w_cnt_mid + (w_push_ok ? CW'(w_push_n) : '0);

        w_err_set = w_req_err
                  | ((w_pop_n  != 3'd0) && !w_pop_ok)
                  | ((w_push_n != 3'd0) && !w_push_ok);
    end

    buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk        (clk),
        .i_wr_en    (w_push_ok & ~w_empty_req & ~rst),
        .i_wr_ptr   (r_wptr),
        .i_wr_bytes (w_push_n),
        .i_wr_dat   (w_push_dat),
        .i_rd_ptr   (r_rptr),
        .i_rd_bytes (w_pop_n),
        .o_rd_dat   (w_rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_tx_dat <= '0;
            r_rx_dat <= '0;
            r_err    <= 1'b0;
        end else if (w_empty_req) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_tx_dat <= '0;
            r_rx_dat <= '0;
            if (clear) begin
                r_err <= 1'b0;
            end
        end else begin
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(w_pop_n);
                if (w_pop_tx) begin
                    r_tx_dat <= w_rd_dat[7:0];
                end else begin
                    r_rx_dat <= w_rd_dat;
                end
            end
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(w_push_n);
            end
            r_count <= OCC_W'(w_cnt_nxt);
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef WIDE_DATA_BUFFER_WATERMARK_EN
    logic r_level_hit;

    always_ff @(posedge clk) begin
        if (rst || w_empty_req) begin
            r_level_hit <= 1'b0;
        end else begin
            r_level_hit <= (w_cnt_nxt >= CW'(WATERMARK));
        end
    end

    assign level_hit = r_level_hit;
`endif

    assign tx_packet_data   = r_tx_dat;
    assign rx_data          = r_rx_dat;
    assign buffer_occupancy = r_count;
    assign buf_err          = r_err;
    assign empty            = (r_count == '0);
    assign full             = (r_count == OCC_W'(DEPTH));

endmodule

// File: tb/tb_wide_data_buffer.sv
// Scoreboard bench for wide_data_buffer: a byte-queue reference model predicts every pop and status.
module tb_wide_data_buffer;
    import wide_buffer_pkg::*;

    localparam int DEPTH = 64;
    localparam int OCC_W = 7;
    localparam int WM    = 32;

    logic             clk = 1'b0;
    logic             rst, clear, flush;
    logic             store_rx_data, get_tx_data, store_tx_data, get_rx_data;
    logic [7:0]       rx_packet_data, tx_packet_data;
    logic [31:0]      tx_data, rx_data;
    logic [1:0]       tx_size, rx_size;
    logic [OCC_W-1:0] buffer_occupancy;
    logic             empty, full, buf_err;
`ifdef WIDE_DATA_BUFFER_WATERMARK_EN
    logic             level_hit;
`endif

    wide_data_buffer #(
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
`ifdef WIDE_DATA_BUFFER_WATERMARK_EN
        ,
        .WATERMARK (WM)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clear            (clear),
        .flush            (flush),
        .store_rx_data    (store_rx_data),
        .rx_packet_data   (rx_packet_data),
        .get_tx_data      (get_tx_data),
        .tx_packet_data   (tx_packet_data),
        .store_tx_data    (store_tx_data),
        .tx_data          (tx_data),
        .tx_size          (tx_size),
        .get_rx_data      (get_rx_data),
        .rx_size          (rx_size),
        .rx_data          (rx_data),
        .buffer_occupancy (buffer_occupancy),
        .empty            (empty),
        .full             (full),
        .buf_err          (buf_err)
`ifdef WIDE_DATA_BUFFER_WATERMARK_EN
        ,
        .level_hit        (level_hit)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        is_tx;
        logic [31:0] val;
    } exp_t;

    logic [7:0]  mdl [$];
    exp_t        exp_q [$];
    logic        m_err;
    logic [7:0]  m_tx;
    logic [31:0] m_rx;
    logic        m_lvl;

    function automatic int sz_n(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    task automatic check_state();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.is_tx) begin
                chk("tx_pop", {24'h0, tx_packet_data}, e.val);
                m_tx = e.val[7:0];
            end else begin
                chk("rx_pop", rx_data, e.val);
                m_rx = e.val;
            end
        end
        chk("occupancy", {25'h0, buffer_occupancy}, mdl.size());
        chk("empty", {31'h0, empty}, {31'h0, mdl.size() == 0});
        chk("full", {31'h0, full}, {31'h0, mdl.size() == DEPTH});
        chk("buf_err", {31'h0, buf_err}, {31'h0, m_err});
        chk("tx_hold", {24'h0, tx_packet_data}, {24'h0, m_tx});
        chk("rx_hold", rx_data, m_rx);
`ifdef WIDE_DATA_BUFFER_WATERMARK_EN
        chk("level_hit", {31'h0, level_hit}, {31'h0, m_lvl});
`endif
    endtask

    // Drive one cycle of requests (at negedge), predict, clock, then check at the next negedge.
    task automatic cyc(input logic srx, input logic [7:0] rxb, input logic gtx,
                       input logic stx, input logic [31:0] txd, input logic [1:0] txs,
                       input logic grx, input logic [1:0] rxs, input logic clr, input logic fl);
        int          pn, wn, cnt_mid;
        logic        ptx, pok;
        logic [31:0] pval, wdat;
        exp_t        e;
        store_rx_data = srx; rx_packet_data = rxb; get_tx_data = gtx;
        store_tx_data = stx; tx_data = txd; tx_size = txs;
        get_rx_data = grx; rx_size = rxs; clear = clr; flush = fl;
        if (clr || fl) begin
            mdl.delete();
            m_tx = '0; m_rx = '0; m_lvl = 1'b0;
            if (clr) m_err = 1'b0;
        end else begin
            pn = 0; ptx = 1'b0;
            if (gtx) begin
                pn = 1; ptx = 1'b1;
                if (grx) m_err = 1'b1;
            end else if (grx) begin
                pn = sz_n(rxs);
                if (pn == 0) m_err = 1'b1;
            end
            pok = (pn > 0) && (pn <= mdl.size());
            if (pn > 0 && !pok) m_err = 1'b1;
            wn = 0; wdat = txd;
            if (srx) begin
                wn = 1; wdat = {24'h0, rxb};
                if (stx) m_err = 1'b1;
            end else if (stx) begin
                wn = sz_n(txs);
                if (wn == 0) m_err = 1'b1;
            end
            cnt_mid = mdl.size() - (pok ? pn : 0);
            if (pok) begin
                pval = '0;
                for (int i = 0; i < pn; i++) pval[8*i +: 8] = mdl.pop_front();
                e.is_tx = ptx; e.val = pval;
                exp_q.push_back(e);
            end
            if (wn > 0) begin
                if (cnt_mid + wn <= DEPTH) begin
                    for (int i = 0; i < wn; i++) mdl.push_back(wdat[8*i +: 8]);
                end else begin
                    m_err = 1'b1;
                end
            end
            m_lvl = (mdl.size() >= WM);
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic idle();                               cyc(0, 8'h0, 0, 0, 32'h0, 2'd0, 0, 2'd0, 0, 0); endtask
    task automatic push_rx(input logic [7:0] b);          cyc(1, b, 0, 0, 32'h0, 2'd0, 0, 2'd0, 0, 0); endtask
    task automatic push_tx(input logic [31:0] d, input logic [1:0] s); cyc(0, 8'h0, 0, 1, d, s, 0, 2'd0, 0, 0); endtask
    task automatic pop_rx(input logic [1:0] s);           cyc(0, 8'h0, 0, 0, 32'h0, 2'd0, 1, s, 0, 0); endtask
    task automatic pop_tx();                             cyc(0, 8'h0, 1, 0, 32'h0, 2'd0, 0, 2'd0, 0, 0); endtask
    task automatic do_clear();                           cyc(0, 8'h0, 0, 0, 32'h0, 2'd0, 0, 2'd0, 1, 0); endtask

    // Reset, optionally with a push and pop in flight that must be discarded.
    task automatic rst_cyc(input logic busy);
        rst = 1'b1;
        store_rx_data = busy; rx_packet_data = 8'hEE; get_tx_data = busy;
        store_tx_data = 1'b0; get_rx_data = 1'b0; clear = 1'b0; flush = 1'b0;
        mdl.delete(); exp_q.delete();
        m_err = 1'b0; m_tx = '0; m_rx = '0; m_lvl = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_state();
    endtask

    logic [7:0] tx_bytes [4];

    initial begin
        rst = 1'b1; clear = 1'b0; flush = 1'b0;
        store_rx_data = 1'b0; get_tx_data = 1'b0; store_tx_data = 1'b0; get_rx_data = 1'b0;
        rx_packet_data = '0; tx_data = '0; tx_size = '0; rx_size = '0;
        @(negedge clk);
        rst_cyc(1'b0);
        chk("reset_empty", {31'h0, empty}, 32'd1);
        chk("reset_full", {31'h0, full}, 32'd0);

        // Four RX bytes read back as one little-endian word.
        for (int k = 1; k <= 4; k++) push_rx(8'(k));
        chk("occ_4", {25'h0, buffer_occupancy}, 32'd4);
        pop_rx(SZ_WORD);
        chk("word_rd", rx_data, 32'h04030201);
        chk("occ_0", {25'h0, buffer_occupancy}, 32'd0);

        // One AHB word drained byte by byte on the USB side.
        tx_bytes[0] = 8'hAA; tx_bytes[1] = 8'hBB; tx_bytes[2] = 8'hCC; tx_bytes[3] = 8'hDD;
        push_tx(32'hDDCCBBAA, SZ_WORD);
        for (int k = 0; k < 4; k++) begin
            pop_tx();
            chk("tx_byte", {24'h0, tx_packet_data}, {24'h0, tx_bytes[k]});
            chk("tx_occ", {25'h0, buffer_occupancy}, 32'(3 - k));
        end
        chk("tx_empty", {31'h0, empty}, 32'd1);

        // Near-full overflow rejection, then fill to exactly DEPTH, then clear.
        for (int k = 0; k < 15; k++) push_tx(32'h10203040 + 32'(k), SZ_WORD);
        for (int k = 0; k < 3; k++) push_rx(8'h80 + 8'(k));
        push_tx(32'h0000BEEF, SZ_HALF);
        chk("ovf_occ", {25'h0, buffer_occupancy}, 32'(DEPTH - 1));
        chk("ovf_err", {31'h0, buf_err}, 32'd1);
        push_rx(8'h77);
        chk("full_hit", {31'h0, full}, 32'd1);
        push_rx(8'h78);
        do_clear();
        chk("clr_occ", {25'h0, buffer_occupancy}, 32'd0);
        chk("clr_err", {31'h0, buf_err}, 32'd0);

        // Walk pointers to DEPTH-2, then a word that wraps mid-write.
        for (int k = 0; k < 15; k++) begin
            push_tx(32'hA0B0C0D0 ^ 32'(k), SZ_WORD);
            pop_rx(SZ_WORD);
        end
        push_tx(32'h00005566, SZ_HALF);
        pop_rx(SZ_HALF);
        push_tx(32'h44332211, SZ_WORD);
        pop_rx(SZ_WORD);
        chk("wrap_word", rx_data, 32'h44332211);

        // Simultaneous pop and push, then flush keeps the sticky error.
        push_tx(32'h0000C3C2, SZ_HALF);
        cyc(0, 8'h0, 1, 1, 32'h0000E1E0, SZ_HALF, 0, 2'd0, 0, 0);
        chk("pp_occ", {25'h0, buffer_occupancy}, 32'd3);
        pop_rx(2'd3);
        chk("bad_size_err", {31'h0, buf_err}, 32'd1);
        cyc(1, 8'h99, 0, 0, 32'h0, 2'd0, 0, 2'd0, 0, 1);
        chk("flush_occ", {25'h0, buffer_occupancy}, 32'd0);
        chk("flush_err", {31'h0, buf_err}, 32'd1);

        // Underflowing pop leaves rx_data alone.
        do_clear();
        push_rx(8'h5A);
        pop_rx(SZ_BYTE);
        pop_rx(SZ_BYTE);
        chk("uflow_hold", rx_data, 32'h0000005A);
        chk("uflow_err", {31'h0, buf_err}, 32'd1);

        // Writer and reader conflicts.
        do_clear();
        cyc(1, 8'h11, 0, 1, 32'hFFFFFFFF, SZ_WORD, 0, 2'd0, 0, 0);
        chk("wr_conf_occ", {25'h0, buffer_occupancy}, 32'd1);
        chk("wr_conf_err", {31'h0, buf_err}, 32'd1);
        do_clear();
        push_tx(32'h0D0C0B0A, SZ_WORD);
        cyc(0, 8'h0, 1, 0, 32'h0, 2'd0, 1, SZ_HALF, 0, 0);
        chk("rd_conf_tx", {24'h0, tx_packet_data}, 32'h0A);
        chk("rd_conf_occ", {25'h0, buffer_occupancy}, 32'd3);

        // Reset with traffic in flight.
        push_rx(8'h31);
        rst_cyc(1'b1);
        chk("rst_busy_occ", {25'h0, buffer_occupancy}, 32'd0);

`ifdef WIDE_DATA_BUFFER_WATERMARK_EN
        for (int k = 1; k <= WM + 1; k++) begin
            push_rx(8'(k));
            chk("wm_edge", {31'h0, level_hit}, {31'h0, k >= WM});
        end
        do_clear();
        chk("wm_clear", {31'h0, level_hit}, 32'd0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst_cyc($urandom_range(0, 1) == 1);
            end else begin
                cyc($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 2) == 0, $urandom, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0);
            end
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wide_data_buffer.md
WIDE_DATA_BUFFER -- requirements
Module: wide_data_buffer

Interface
REQ-001 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL take parameter DEPTH, default 64; buffer capacity in bytes, a power of 2 and at least 8.
REQ-003 SHALL take parameter OCC_W, default $clog2(DEPTH)+1; occupancy width.
REQ-004 SHALL have ports, one per line as follows: name, direction, width, meaning.
  clk  in  1  clock
  rst  in  1  sync active-high reset
  clear  in  1  AHB-side sync empty plus error clear
  flush  in  1  USB-side sync empty
  store_rx_data  in  1  push 1 byte from USB RX
  rx_packet_data  in  8  RX byte
  get_tx_data  in  1  pop 1 byte to USB TX
  tx_packet_data  out  8  registered TX byte
  store_tx_data  in  1  push from AHB
  tx_data  in  32  AHB write word, little-endian
  tx_size  in  2  push size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = illegal
  get_rx_data  in  1  pop to AHB
  rx_size  in  2  pop size, same encoding as tx_size
  rx_data  out  32  registered AHB read word
  buffer_occupancy  out  OCC_W  bytes held
  empty  out  1  occupancy == 0
  full  out  1  occupancy == DEPTH
  buf_err  out  1  sticky error

Function
REQ-005 SHALL implement one circular byte store with read pointer, write pointer and count; pointers wrap modulo DEPTH.
REQ-006 SHALL select at most one writer per cycle: store_rx_data (1 byte) or store_tx_data (size N); if both are asserted, RX wins, TX is dropped and buf_err sets.
REQ-007 SHALL select at most one reader per cycle: get_tx_data (1 byte) or get_rx_data (size N); if both are asserted, get_tx_data wins, get_rx_data is dropped and buf_err sets.
REQ-008 SHALL store the N-byte push as tx_data[7:0] at wptr, [15:8] at wptr+1, and so on, with wrap allowed mid-word.
REQ-009 SHALL, on an accepted pop, register the bytes at rptr into tx_packet_data, or into rx_data[8N-1:0] with the upper bytes zeroed, at that edge; rptr and count update at the same edge, so latency is 1 cycle.
REQ-010 SHALL hold a data output when no pop occurs.
REQ-011 SHALL update count as count + push_N - pop_N when push and pop occur in the same cycle.
REQ-012 SHALL accept a pop only if pop_N <= count before the edge; otherwise pointers, count and outputs are unchanged and buf_err sets.
REQ-013 SHALL accept a push only if count - accepted pop_N + push_N <= DEPTH; otherwise it is dropped whole, with no partial write, and buf_err sets.
REQ-014 SHALL treat size 3 as a rejected operation that sets buf_err.
REQ-015 SHALL, on clear or flush, zero pointers, count, tx_packet_data and rx_data at the edge and ignore all same-cycle push and pop requests.
REQ-016 SHALL clear buf_err only on clear or rst; flush leaves buf_err unchanged.
REQ-017 SHALL derive empty and full combinationally from the registered count.

Reset
REQ-018 SHALL apply priority rst > clear/flush > pop/push.
REQ-019 SHALL, on rst, set pointers, count, tx_packet_data, rx_data and buf_err to 0, so empty = 1 and full = 0.
REQ-020 SHALL honour rst asserted mid-burst, discarding the in-flight operation.
REQ-021 SHALL leave buffer RAM contents unreset.

Configuration
REQ-022 SHALL, with WIDE_DATA_BUFFER_WATERMARK_EN defined, add parameter WATERMARK (default DEPTH/2) and output level_hit (1 bit, registered) = 1 when next-cycle count >= WATERMARK, and level_hit = 0 on reset, clear and flush.
REQ-023 SHALL, without WIDE_DATA_BUFFER_WATERMARK_EN, have neither the parameter nor the port, with all other behaviour identical.

Structure
REQ-024 SHALL define in package wide_buffer_pkg: enum size_t (SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2), localparam WORD_BYTES = 4, and a function size_to_bytes.
REQ-025 SHALL place storage in sub-module buffer_ram (DEPTH x 8, one write port of 1-4 bytes and one read port of 1-4 bytes, with wrap-aware byte-lane addressing); the control logic stays in wide_data_buffer.

Verification
REQ-026 SHALL cover: rst, then push RX bytes 1, 2, 3, 4 on consecutive cycles, then get_rx_data with SZ_WORD -> rx_data = 32'h04030201 one cycle later, occupancy 4 -> 0.
REQ-027 SHALL cover: store_tx_data with SZ_WORD 32'hDDCCBBAA, then 4 get_tx_data cycles -> tx_packet_data AA, BB, CC, DD, occupancy 3, 2, 1, 0, empty = 1.
REQ-028 SHALL cover: fill to DEPTH-1, then SZ_HALF push -> rejected, occupancy stays DEPTH-1, buf_err = 1; then clear -> occupancy 0, buf_err = 0.
REQ-029 SHALL cover: pointers at DEPTH-2, push SZ_WORD 32'h44332211 that wraps, then pop SZ_WORD -> rx_data = 32'h44332211.
REQ-030 SHALL cover: occupancy 2, same-cycle get_tx_data and SZ_HALF push -> occupancy 3; then flush with store_rx_data high -> occupancy 0, push ignored, buf_err unchanged.
REQ-031 SHALL cover: empty buffer, get_rx_data SZ_BYTE -> rx_data unchanged, buf_err = 1; and WATERMARK = 32 -> level_hit rises on the edge where count reaches 32.
